// File: rtl/prescaled_mod_counter_if.sv
// Control and status bundle for prescaled_mod_counter: the driver side (master)
// issues en/up/mode/load, the counter side (slave) returns the count and pulses.
interface prescaled_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             tc;
  logic             done;
  logic             dir;

  modport master (
    output en, up, mode, load, load_val,
    input  q, tick, tc, done, dir
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output q, tick, tc, done, dir
  );
endinterface

// File: rtl/prescaled_mod_counter.sv
// Modulo counter stepped by an internal prescaler strobe, with wrap, saturate,
// one-shot and bounce modes; all outputs are registered on the single clock.
module prescaled_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  prescaled_mod_counter_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH + 1)'(MODULUS);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_BOUNCE  = 2'b11;

  logic [PW-1:0]    p;
  logic [WIDTH-1:0] q_r;
  logic             tick_r, tc_r, done_r, dir_r;

  logic             step_due, eff_up, at_term, land_fwd, land_rev;
  logic [WIDTH-1:0] fwd, rev, load_q;
  logic [WIDTH-1:0] q_nxt;
  logic             tick_nxt, tc_nxt, done_nxt, dir_nxt;

  assign step_due = bus.en && (p == P_LAST);
  assign eff_up   = (bus.mode == MODE_BOUNCE) ? dir_r : bus.up;
  assign at_term  = eff_up ? (q_r == Q_MAX) : (q_r == '0);

  // fwd wraps explicitly at both ends; rev is only used when sitting on the
  // terminal value, so it never leaves the 0..MODULUS-1 range.
  assign fwd = eff_up ? ((q_r == Q_MAX) ? '0 : q_r + 1'b1)
                      : ((q_r == '0)    ? Q_MAX : q_r - 1'b1);
  assign rev = eff_up ? q_r - 1'b1 : q_r + 1'b1;

  assign land_fwd = eff_up ? (fwd == Q_MAX) : (fwd == '0);
  assign land_rev = eff_up ? (rev == '0)    : (rev == Q_MAX);

  assign load_q = ({1'b0, bus.load_val} >= MOD_W) ? Q_MAX : bus.load_val;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    q_nxt    = q_r;
    tick_nxt = 1'b0;
    tc_nxt   = 1'b0;
    done_nxt = (bus.mode == MODE_ONESHOT) ? done_r : 1'b0;
    dir_nxt  = (bus.mode == MODE_BOUNCE)  ? dir_r  : bus.up;
    if (step_due) begin
      case (bus.mode)
        MODE_WRAP: begin
          q_nxt    = fwd;
          tick_nxt = 1'b1;
          tc_nxt   = land_fwd;
        end
        MODE_SAT: begin
          tick_nxt = 1'b1;
          if (!at_term) begin
            q_nxt  = fwd;
            tc_nxt = land_fwd;
          end
        end
        MODE_ONESHOT: begin
          if (!done_r) begin
            tick_nxt = 1'b1;
            if (at_term) begin
              done_nxt = 1'b1;
            end else begin
              q_nxt    = fwd;
              tc_nxt   = land_fwd;
              done_nxt = land_fwd;
            end
          end
        end
        default: begin
          tick_nxt = 1'b1;
          if (!at_term) begin
            q_nxt   = fwd;
            tc_nxt  = land_fwd;
            dir_nxt = land_fwd ? ~dir_r : dir_r;
          end else begin
            // Entered bounce already parked on the terminal: reflect first.
            q_nxt   = rev;
            tc_nxt  = land_rev;
            dir_nxt = land_rev ? dir_r : ~dir_r;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      p      <= '0;
      q_r    <= '0;
      tick_r <= 1'b0;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
      dir_r  <= 1'b1;
    end else if (bus.load) begin
      p      <= '0;
      q_r    <= load_q;
      tick_r <= 1'b0;
      tc_r   <= 1'b0;
      done_r <= 1'b0;
      dir_r  <= bus.up;
    end else begin
      if (bus.en) p <= step_due ? '0 : p + 1'b1;
      q_r    <= q_nxt;
      tick_r <= tick_nxt;
      tc_r   <= tc_nxt;
      done_r <= done_nxt;
      dir_r  <= dir_nxt;
    end
  end

  assign bus.q    = q_r;
  assign bus.tick = tick_r;
  assign bus.tc   = tc_r;
  assign bus.done = done_r;
  assign bus.dir  = dir_r;

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// Scoreboard bench: the driver predicts each cycle's outputs from an arithmetic
// model and queues them; an independent monitor pops and compares on negedge.
module tb_prescaled_mod_counter;
  localparam int W = 4;
  localparam int M = 10;
  localparam int P = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tick;
    logic         tc;
    logic         done;
    logic         dir;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prescaled_mod_counter_if #(.WIDTH(W)) bus ();

  prescaled_mod_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(P)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: count, enabled cycles into the current period, flags.
  int mq, mp;
  bit mdone, mdir, mtick, mtc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit en_i, input bit u,
                            input logic [1:0] md, input bit ld, input int lv);
    bit due, d;
    int term, nxt;
    if (r) begin
      mq = 0; mp = 0; mdone = 0; mdir = 1; mtick = 0; mtc = 0;
      return;
    end
    if (ld) begin
      mq = (lv >= M) ? M - 1 : lv; mp = 0; mdone = 0; mdir = u; mtick = 0; mtc = 0;
      return;
    end
    mtick = 0;
    mtc   = 0;
    due   = en_i && (mp == P - 1);
    if (en_i) mp = (mp + 1) % P;
    if (md != 2'b10) mdone = 0;
    d = (md == 2'b11) ? mdir : u;
    if (due) begin
      term = d ? M - 1 : 0;
      nxt  = d ? (mq + 1) % M : (mq + M - 1) % M;
      case (md)
        2'b00: begin
          mq = nxt; mtick = 1; mtc = (nxt == term);
        end
        2'b01: begin
          mtick = 1;
          if (mq != term) begin mq = nxt; mtc = (nxt == term); end
        end
        2'b10: begin
          if (!mdone) begin
            mtick = 1;
            if (mq == term) mdone = 1;
            else begin
              mq = nxt;
              if (nxt == term) begin mtc = 1; mdone = 1; end
            end
          end
        end
        default: begin
          mtick = 1;
          if (mq == term) d = !d;
          mq = d ? mq + 1 : mq - 1;
          if (mq == (d ? M - 1 : 0)) begin mtc = 1; d = !d; end
        end
      endcase
    end
    mdir = d;
  endtask

  // Apply one cycle of inputs, predict the post-edge outputs, queue them after the edge.
  task automatic drive(input bit r, input bit en_i, input bit u, input logic [1:0] md,
                       input bit ld, input logic [W-1:0] lv);
    obs_t e;
    reset        = r;
    bus.en       = en_i;
    bus.up       = u;
    bus.mode     = md;
    bus.load     = ld;
    bus.load_val = lv;
    model_edge(r, en_i, u, md, ld, int'(lv));
    e.q    = mq[W-1:0];
    e.tick = mtick;
    e.tc   = mtc;
    e.done = mdone;
    e.dir  = mdir;
    @(posedge clk);
    exp_q.push_back(e);
    #2;
  endtask

  task automatic run(input int n, input bit en_i, input bit u, input logic [1:0] md);
    for (int i = 0; i < n; i++) drive(1'b0, en_i, u, md, 1'b0, '0);
  endtask

  initial begin : monitor
    obs_t ex, act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        act = {bus.q, bus.tick, bus.tc, bus.done, bus.dir};
        check("outputs{q,tick,tc,done,dir}", 32'(act), 32'(ex));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit r, ld, en_r, u_r;
    logic [1:0] md_r;
    @(posedge clk);
    #2;

    // Reset state
    drive(1, 0, 1, 2'b00, 0, '0);
    drive(1, 0, 1, 2'b00, 0, '0);
    check("reset_q", bus.q, 0);
    check("reset_dir", bus.dir, 1);
    check("reset_pulses", {bus.tick, bus.tc, bus.done}, 0);

    // 1: wrap up, first step on the 4th enabled edge
    run(4, 1, 1, 2'b00);
    check("first_step_q", bus.q, 1);
    check("first_step_tick", bus.tick, 1);
    run(40, 1, 1, 2'b00);

    // 2: wrap down with a 3-cycle en pause mid-period
    run(6, 1, 0, 2'b00);
    run(3, 0, 0, 2'b00);
    run(40, 1, 0, 2'b00);

    // 3: saturate
    drive(0, 1, 1, 2'b01, 1, 4'd8);
    run(30, 1, 1, 2'b01);
    check("saturate_hold_q", bus.q, 9);

    // 4: one-shot
    drive(0, 1, 1, 2'b10, 1, 4'd7);
    run(20, 1, 1, 2'b10);
    check("oneshot_q", bus.q, 9);
    check("oneshot_done", bus.done, 1);
    drive(0, 1, 1, 2'b10, 1, 4'd3);
    check("oneshot_reload_q", bus.q, 3);
    check("oneshot_reload_done", bus.done, 0);

    // 5: bounce from reset; 20 steps land on 2 heading up
    drive(1, 1, 1, 2'b11, 0, '0);
    run(80, 1, 1, 2'b11);
    check("bounce_q", bus.q, 2);
    check("bounce_dir", bus.dir, 1);

    // 6: load clamp, load beating a due step, reset beating load
    drive(0, 1, 1, 2'b00, 1, 4'd12);
    check("clamp_q", bus.q, 9);
    run(3, 1, 1, 2'b00);
    drive(0, 1, 1, 2'b00, 1, 4'd5);
    check("load_over_step_q", bus.q, 5);
    check("load_over_step_pulses", {bus.tick, bus.tc}, 0);
    run(2, 1, 0, 2'b00);
    drive(1, 1, 0, 2'b00, 1, 4'd7);
    check("reset_over_load_q", bus.q, 0);
    check("reset_over_load_dir", bus.dir, 1);
    check("reset_over_load_pulses", {bus.tick, bus.tc, bus.done}, 0);

    // Randomised traffic against the model
    en_r = 1; u_r = 1; md_r = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 29) == 0);
      en_r = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) u_r = ~u_r;
      if ($urandom_range(0, 39) == 0) md_r = 2'($urandom_range(0, 3));
      drive(r, en_r, u_r, md_r, ld, 4'($urandom_range(0, 15)));
    end
    drive(0, 0, 1, 2'b00, 0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
